// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port 1-cycle-latency SRAM between two
// Avalon-MM requesters with round-robin grant, bounded lock and read routing.
// Optional build macro SRAM_ARB_PROTECT_EN: write-protects [0,PROT_TOP) against
// requester 1 and raises a sticky prot_err on a violating write.
module sram_port_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned MAX_LOCK = 16,
    parameter int unsigned PROT_TOP = 64
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    input  logic          m0_lock,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,

    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    input  logic          m1_lock,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,

    output logic [AW-1:0] sram_address,
    output logic [3:0]    sram_byteenable,
    output logic          sram_chipselect,
    output logic          sram_write,
    output logic [31:0]   sram_writedata,
    output logic          sram_clken,
    input  logic [31:0]   sram_readdata,

    output logic          prot_err
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    logic [1:0]    r_state;
    logic          r_rr_last;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rd_vld;
    logic          r_rd_id;

    logic [1:0]    w_state_nxt;
    logic          w_rr_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;

    logic          w_req0;
    logic          w_req1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_gnt_wr;
    logic          w_gnt_lock;
    logic          w_prot_hit;

    // A request is a read or a write; a simultaneous read+write is a write.
    assign w_req0     = m0_read | m0_write;
    assign w_req1     = m1_read | m1_write;
    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign w_gnt_wr   = w_gnt1 ? m1_write : m0_write;
    assign w_gnt_lock = w_gnt1 ? m1_lock  : m0_lock;
    assign w_cnt_inc  = r_lock_cnt + CW'(1);

    // Grant selection: lock owner only, otherwise sole requester or round-robin.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 & w_req1) begin
                        w_gnt0 = r_rr_last;
                        w_gnt1 = ~r_rr_last;
                    end else begin
                        w_gnt0 = w_req0;
                        w_gnt1 = w_req1;
                    end
                end
                S_LOCK0: w_gnt0 = w_req0;
                S_LOCK1: w_gnt1 = w_req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_PROTECT_EN
    assign w_prot_hit = w_gnt1 & m1_write & (32'(m1_address) < PROT_TOP);

    logic r_prot_err;

    // Sticky record of any blocked write into the protected window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prot_err <= 1'b0;
        end else if (w_prot_hit) begin
            r_prot_err <= 1'b1;
        end
    end

    assign prot_err = r_prot_err;
`else
    assign w_prot_hit = 1'b0;
    assign prot_err   = 1'b0;
`endif

    // SRAM command mux; a blocked write is granted but never reaches the array.
    always_comb begin
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        sram_address    = '0;
        sram_byteenable = '0;
        sram_writedata  = '0;
        if (w_gnt_any & ~w_prot_hit) begin
            sram_chipselect = 1'b1;
            sram_write      = w_gnt_wr;
            if (w_gnt1) begin
                sram_address    = m1_address;
                sram_byteenable = m1_byteenable;
                sram_writedata  = m1_writedata;
            end else begin
                sram_address    = m0_address;
                sram_byteenable = m0_byteenable;
                sram_writedata  = m0_writedata;
            end
        end
    end

    // Lock tracking: lock_cnt counts granted cycles of the current lock run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_lock_cnt;
        w_rr_nxt    = w_gnt_any ? w_gnt1 : r_rr_last;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_any & w_gnt_lock) begin
                    w_state_nxt = w_gnt1 ? S_LOCK1 : S_LOCK0;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_LOCK0, S_LOCK1: begin
                if (!w_gnt_any || !w_gnt_lock || (w_cnt_inc == CW'(MAX_LOCK))) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Arbitration state registers; rr_last=1 lets m0 win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rr_last  <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_last  <= w_rr_nxt;
            r_lock_cnt <= w_cnt_nxt;
        end
    end

    // Remember which requester owns the read data returning next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_vld <= 1'b0;
            r_rd_id  <= 1'b0;
        end else begin
            r_rd_vld <= w_gnt_any & ~w_gnt_wr;
            r_rd_id  <= w_gnt1;
        end
    end

    assign m0_waitrequest   = ~reset_n | (w_req0 & ~w_gnt0);
    assign m1_waitrequest   = ~reset_n | (w_req1 & ~w_gnt1);
    assign m0_readdatavalid = r_rd_vld & ~r_rd_id;
    assign m1_readdatavalid = r_rd_vld &  r_rd_id;
    assign m0_readdata      = sram_readdata;
    assign m1_readdata      = sram_readdata;
    assign sram_clken       = 1'b1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration/memory model.
module tb_sram_port_arbiter;

    localparam int AW       = 10;
    localparam int MAX_LOCK = 16;
    localparam int PROT_TOP = 64;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic          m0_read, m1_read, m0_write, m1_write, m0_lock, m1_lock;
    logic [31:0]   m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [31:0]   m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] sram_address;
    logic [3:0]    sram_byteenable;
    logic          sram_chipselect, sram_write, sram_clken;
    logic [31:0]   sram_writedata;
    logic [31:0]   sram_readdata;
    logic          prot_err;

    int checks   = 0;
    int failures = 0;

    sram_port_arbiter #(.AW(AW), .MAX_LOCK(MAX_LOCK), .PROT_TOP(PROT_TOP)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .sram_address(sram_address), .sram_byteenable(sram_byteenable),
        .sram_chipselect(sram_chipselect), .sram_write(sram_write),
        .sram_writedata(sram_writedata), .sram_clken(sram_clken),
        .sram_readdata(sram_readdata), .prot_err(prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
    endfunction

    // Behavioural SRAM: 1-cycle read latency, byte-enabled write.
    bit          sram_ready = 1'b0;
    logic [31:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_val(i);
            sram_ready <= 1'b1;
        end else if (sram_chipselect) begin
            if (sram_write) begin
                for (int b = 0; b < 4; b++)
                    if (sram_byteenable[b]) sram_mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
            end else begin
                sram_readdata <= sram_mem[sram_address];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:1023];
    int          mdl_rr_last, mdl_owner, mdl_cnt, mdl_rd_id;
    bit          mdl_rd_vld, mdl_prot;
    logic [31:0] mdl_rd_data;

    int          e_gnt;
    bit          e_wait0, e_wait1, e_cs, e_we, e_rdv0, e_rdv1, e_win_wr, e_win_lock, e_blk;
    logic [9:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;

    task automatic model_reset();
        mdl_rr_last = 1;
        mdl_owner   = -1;
        mdl_cnt     = 0;
        mdl_rd_vld  = 0;
        mdl_rd_id   = 0;
        mdl_prot    = 0;
    endtask

    task automatic model_eval();
        bit r0, r1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        e_gnt = -1;
        if (reset_n === 1'b1) begin
            if (mdl_owner == 0)      begin if (r0) e_gnt = 0; end
            else if (mdl_owner == 1) begin if (r1) e_gnt = 1; end
            else if (r0 && r1)       e_gnt = 1 - mdl_rr_last;
            else if (r0)             e_gnt = 0;
            else if (r1)             e_gnt = 1;
        end
        e_wait0    = (reset_n !== 1'b1) || (r0 && e_gnt != 0);
        e_wait1    = (reset_n !== 1'b1) || (r1 && e_gnt != 1);
        e_win_wr   = (e_gnt == 1) ? m1_write      : m0_write;
        e_win_lock = (e_gnt == 1) ? m1_lock       : m0_lock;
        e_addr     = (e_gnt == 1) ? m1_address    : m0_address;
        e_be       = (e_gnt == 1) ? m1_byteenable : m0_byteenable;
        e_wdata    = (e_gnt == 1) ? m1_writedata  : m0_writedata;
        e_blk      = 0;
`ifdef SRAM_ARB_PROTECT_EN
        e_blk = (e_gnt == 1) && m1_write && (int'(m1_address) < PROT_TOP);
`endif
        e_cs   = (e_gnt >= 0) && !e_blk;
        e_we   = e_cs && e_win_wr;
        e_rdv0 = mdl_rd_vld && (mdl_rd_id == 0);
        e_rdv1 = mdl_rd_vld && (mdl_rd_id == 1);
    endtask

    task automatic model_commit();
        if (reset_n !== 1'b1) return;
        mdl_rd_vld = (e_gnt >= 0) && !e_win_wr;
        if (mdl_rd_vld) begin
            mdl_rd_id   = e_gnt;
            mdl_rd_data = ref_mem[e_addr];
        end
        if (e_we)
            for (int b = 0; b < 4; b++)
                if (e_be[b]) ref_mem[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
        if (e_blk) mdl_prot = 1;
        if (mdl_owner < 0) begin
            if (e_gnt >= 0 && e_win_lock) begin
                mdl_owner = e_gnt;
                mdl_cnt   = 1;
            end
        end else if (e_gnt < 0 || !e_win_lock) begin
            mdl_owner = -1;
        end else begin
            mdl_cnt++;
            if (mdl_cnt == MAX_LOCK) mdl_owner = -1;
        end
        if (e_gnt >= 0) mdl_rr_last = e_gnt;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        m0_read = 1; m1_write = 1;
        #3;
        checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_wait0 got=%b exp=1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_wait1 got=%b exp=1", m1_waitrequest); end
        checks++; if (sram_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs got=%b exp=0", sram_chipselect); end
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("FAIL rst_rdv got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (prot_err !== 1'b0) begin failures++; $display("FAIL rst_prot got=%b exp=0", prot_err); end
        apply_reset();
        #3;
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b00) begin failures++; $display("FAIL rel_wait got=%b%b exp=00", m0_waitrequest, m1_waitrequest); end
        checks++; if (sram_clken !== 1'b1) begin failures++; $display("FAIL clken got=%b exp=1", sram_clken); end
        tick();
    endtask

    task automatic test_write_read();
        m0_write = 1; m0_address = 10'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        #3;
        checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL wr_wait0 got=%b exp=0", m0_waitrequest); end
        checks++; if ({sram_chipselect, sram_write} !== 2'b11) begin failures++; $display("FAIL wr_cmd got=%b%b exp=11", sram_chipselect, sram_write); end
        checks++; if (sram_address !== 10'h005 || sram_writedata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_bus got=%h/%h exp=005/deadbeef", sram_address, sram_writedata); end
        tick();
        m0_write = 0; m0_read = 1;
        #3;
        checks++; if ({sram_chipselect, sram_write} !== 2'b10) begin failures++; $display("FAIL rd_cmd got=%b%b exp=10", sram_chipselect, sram_write); end
        tick();
        drive_idle();
        #3;
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin failures++; $display("FAIL rd_rdv got=%b%b exp=10", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", m0_readdata); end
        tick();
    endtask

    task automatic test_round_robin();
        int prev;
        apply_reset();
        m0_read = 1; m0_address = 10'h021;
        m1_read = 1; m1_address = 10'h042;
        prev = -1;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) drive_idle();
            #3;
            if (k < 6) begin
                checks++; if (m0_waitrequest !== (k % 2 != 0)) begin failures++; $display("FAIL rr_wait0 k=%0d got=%b exp=%b", k, m0_waitrequest, k % 2 != 0); end
                checks++; if (m1_waitrequest !== (k % 2 != 1)) begin failures++; $display("FAIL rr_wait1 k=%0d got=%b exp=%b", k, m1_waitrequest, k % 2 != 1); end
            end
            if (prev >= 0) begin
                checks++; if (m0_readdatavalid !== (prev == 0) || m1_readdatavalid !== (prev == 1)) begin failures++; $display("FAIL rr_rdv k=%0d got=%b%b exp_id=%0d", k, m0_readdatavalid, m1_readdatavalid, prev); end
                checks++; if (m0_readdata !== init_val(prev == 0 ? 'h21 : 'h42)) begin failures++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, m0_readdata, init_val(prev == 0 ? 'h21 : 'h42)); end
            end
            prev = k % 2;
            tick();
        end
    endtask

    task automatic test_lock();
        apply_reset();
        m1_read = 1; m1_address = 10'h042;
        m0_read = 1; m0_address = 10'h021; m0_lock = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) m0_lock = 0;
            #3;
            checks++; if (m0_waitrequest !== (k == 4)) begin failures++; $display("FAIL lock_wait0 k=%0d got=%b exp=%b", k, m0_waitrequest, k == 4); end
            checks++; if (m1_waitrequest !== (k != 4)) begin failures++; $display("FAIL lock_wait1 k=%0d got=%b exp=%b", k, m1_waitrequest, k != 4); end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_lock_max();
        int g;
        apply_reset();
        m1_read = 1; m1_lock = 1; m1_address = 10'h042;
        for (int k = 0; k < 18; k++) begin
            if (k == 1) begin m0_read = 1; m0_address = 10'h021; end
            g = (k == 16) ? 0 : 1;
            #3;
            checks++; if (m0_waitrequest !== (k >= 1 && g != 0)) begin failures++; $display("FAIL lmax_wait0 k=%0d got=%b exp=%b", k, m0_waitrequest, k >= 1 && g != 0); end
            checks++; if (m1_waitrequest !== (g != 1)) begin failures++; $display("FAIL lmax_wait1 k=%0d got=%b exp=%b", k, m1_waitrequest, g != 1); end
            tick();
        end
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_byteenable();
        apply_reset();
        m0_write = 1; m0_address = 10'h030; m0_writedata = 32'h11223344; m0_byteenable = 4'hF;
        tick();
        m0_writedata = 32'h0000AB00; m0_byteenable = 4'b0010;
        #3;
        checks++; if (sram_chipselect !== 1'b1 || sram_byteenable !== 4'b0010) begin failures++; $display("FAIL be_bus got=%b/%b exp=1/0010", sram_chipselect, sram_byteenable); end
        tick();
        m0_write = 0; m0_read = 1;
        tick();
        drive_idle();
        #3;
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1122AB44) begin failures++; $display("FAIL be_data got=%b/%h exp=1/1122ab44", m0_readdatavalid, m0_readdata); end
        tick();
    endtask

    task automatic test_protect();
        bit          prot_on;
        logic [31:0] exp_d;
        prot_on = 0;
`ifdef SRAM_ARB_PROTECT_EN
        prot_on = 1;
`endif
        exp_d = prot_on ? init_val('h10) : 32'h1;
        apply_reset();
        m1_write = 1; m1_address = 10'h010; m1_writedata = 32'h1; m1_byteenable = 4'hF;
        #3;
        checks++; if (m1_waitrequest !== 1'b0) begin failures++; $display("FAIL prot_wait1 got=%b exp=0", m1_waitrequest); end
        checks++; if (sram_chipselect !== !prot_on) begin failures++; $display("FAIL prot_cs got=%b exp=%b", sram_chipselect, !prot_on); end
        tick();
        m1_address = 10'(PROT_TOP); m1_writedata = 32'h55;
        #3;
        checks++; if (sram_chipselect !== 1'b1 || sram_address !== 10'(PROT_TOP)) begin failures++; $display("FAIL prot_edge got=%b/%h exp=1/%h", sram_chipselect, sram_address, 10'(PROT_TOP)); end
        tick();
        drive_idle();
        #3;
        checks++; if (prot_err !== prot_on) begin failures++; $display("FAIL prot_flag got=%b exp=%b", prot_err, prot_on); end
        m0_read = 1; m0_address = 10'h010;
        tick();
        drive_idle();
        #3;
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== exp_d) begin failures++; $display("FAIL prot_mem got=%b/%h exp=1/%h", m0_readdatavalid, m0_readdata, exp_d); end
        checks++; if (prot_err !== prot_on) begin failures++; $display("FAIL prot_hold got=%b exp=%b", prot_err, prot_on); end
        tick();
        // reset while a read return is pending
        m0_read = 1; m0_address = 10'h021;
        tick();
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        #3;
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_rdv got=%b exp=0", m0_readdatavalid); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #3;
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("FAIL midrst_rel got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (prot_err !== 1'b0) begin failures++; $display("FAIL midrst_prot got=%b exp=0", prot_err); end
        tick();
    endtask

    task automatic test_random();
        bit          pv[2], prd[2], pwr[2], plk[2];
        logic [9:0]  pa[2];
        logic [3:0]  pbe[2];
        logic [31:0] pd[2];
        int          g, kind;
        apply_reset();
        pv[0] = 0; pv[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pv[m] && ($urandom % 3 != 0)) begin
                    kind   = int'($urandom % 8);
                    pv[m]  = 1;
                    prd[m] = (kind < 4) || (kind == 7);
                    pwr[m] = (kind >= 4);
                    pa[m]  = (m == 1 && ($urandom % 3 == 0)) ? 10'($urandom_range(56, 71)) : 10'($urandom % 16);
                    pbe[m] = 4'($urandom);
                    pd[m]  = $urandom;
                    plk[m] = ($urandom % 3 == 0);
                end
            end
            m0_read = pv[0] & prd[0]; m0_write = pv[0] & pwr[0]; m0_lock = plk[0];
            m0_address = pa[0]; m0_byteenable = pbe[0]; m0_writedata = pd[0];
            m1_read = pv[1] & prd[1]; m1_write = pv[1] & pwr[1]; m1_lock = plk[1];
            m1_address = pa[1]; m1_byteenable = pbe[1]; m1_writedata = pd[1];
            #3;
            model_eval();
            checks++; if (m0_waitrequest !== e_wait0) begin failures++; $display("FAIL rnd_wait0 c=%0d got=%b exp=%b", c, m0_waitrequest, e_wait0); end
            checks++; if (m1_waitrequest !== e_wait1) begin failures++; $display("FAIL rnd_wait1 c=%0d got=%b exp=%b", c, m1_waitrequest, e_wait1); end
            checks++; if (sram_chipselect !== e_cs || sram_write !== e_we) begin failures++; $display("FAIL rnd_cmd c=%0d got=%b%b exp=%b%b", c, sram_chipselect, sram_write, e_cs, e_we); end
            if (e_cs) begin
                checks++; if (sram_address !== e_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, sram_address, e_addr); end
            end
            if (e_we) begin
                checks++; if (sram_writedata !== e_wdata || sram_byteenable !== e_be) begin failures++; $display("FAIL rnd_wbus c=%0d got=%h/%h exp=%h/%h", c, sram_writedata, sram_byteenable, e_wdata, e_be); end
            end
            checks++; if (m0_readdatavalid !== e_rdv0 || m1_readdatavalid !== e_rdv1) begin failures++; $display("FAIL rnd_rdv c=%0d got=%b%b exp=%b%b", c, m0_readdatavalid, m1_readdatavalid, e_rdv0, e_rdv1); end
            if (e_rdv0) begin
                checks++; if (m0_readdata !== mdl_rd_data) begin failures++; $display("FAIL rnd_rdata0 c=%0d got=%h exp=%h", c, m0_readdata, mdl_rd_data); end
            end
            if (e_rdv1) begin
                checks++; if (m1_readdata !== mdl_rd_data) begin failures++; $display("FAIL rnd_rdata1 c=%0d got=%h exp=%h", c, m1_readdata, mdl_rd_data); end
            end
            checks++; if (prot_err !== mdl_prot) begin failures++; $display("FAIL rnd_prot c=%0d got=%b exp=%b", c, prot_err, mdl_prot); end
            g = e_gnt;
            tick();
            if (g >= 0) pv[g] = 0;
        end
        drive_idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        drive_idle();
        model_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock();
        test_lock_max();
        test_byteenable();
        test_protect();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
